// File: rtl/control_unit_fft_iter_pipe_if.sv
// rtl/control_unit_fft_iter_pipe_if.sv - control/status bundle of the pipelined FFT sequencer
// Purpose: groups the cycle enable, start/abort request and every sequencer status
//          and strobe into one bundle.
// master : drives EN, START, ABORT, N_LOG2; observes status and strobes.
// slave  : the sequencer; receives the requests, drives BUSY, DONE, ERR, RD_EN,
//          RD_BUT_IDX, WR_EN, WR_BUT_IDX, LAY_IDX, LAY_EN, LAST_LAY, ADDR_RST.
interface control_unit_fft_iter_pipe_if #(
  parameter int LayWL  = 4,
  parameter int ButtWL = 9
);
  logic              EN;
  logic              START;
  logic              ABORT;
  logic [LayWL-1:0]  N_LOG2;
  logic              BUSY;
  logic              DONE;
  logic              ERR;
  logic              RD_EN;
  logic [ButtWL-1:0] RD_BUT_IDX;
  logic              WR_EN;
  logic [ButtWL-1:0] WR_BUT_IDX;
  logic [LayWL-1:0]  LAY_IDX;
  logic              LAY_EN;
  logic              LAST_LAY;
  logic              ADDR_RST;

  modport master (
    output EN, START, ABORT, N_LOG2,
    input  BUSY, DONE, ERR, RD_EN, RD_BUT_IDX, WR_EN, WR_BUT_IDX,
           LAY_IDX, LAY_EN, LAST_LAY, ADDR_RST
  );

  modport slave (
    input  EN, START, ABORT, N_LOG2,
    output BUSY, DONE, ERR, RD_EN, RD_BUT_IDX, WR_EN, WR_BUT_IDX,
           LAY_IDX, LAY_EN, LAST_LAY, ADDR_RST
  );
endinterface

// File: rtl/control_unit_fft_iter_pipe.sv
// rtl/control_unit_fft_iter_pipe.sv - pipelined read/write-back sequencer for the iterative radix-2 FFT
// Purpose: issues one butterfly read per enabled cycle, retires each write-back
//          BUT_LAT enabled cycles later, and steps through the layers of a 2^N_LOG2 FFT.
// Ports  : CLK  - clock, posedge
//          RST  - synchronous active-high reset
//          bus  - slave side of control_unit_fft_iter_pipe_if (requests in, status/strobes out)
module control_unit_fft_iter_pipe #(
  parameter int LAYERS_MAX = 10,
  parameter int LayWL      = 4,
  parameter int ButtWL     = 9,
  parameter int BUT_LAT    = 3
) (
  input  logic CLK,
  input  logic RST,
  control_unit_fft_iter_pipe_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [LayWL-1:0]  cfg;
  logic [LayWL-1:0]  lay_idx;
  logic [ButtWL-1:0] rd_cnt;
  logic [ButtWL-1:0] wr_cnt;
  logic [BUT_LAT-1:0] vpipe;
  logic [BUT_LAT:0]   vpipe_shift;

  logic [ButtWL:0]   butts_m1;
  logic              rd_last, wr_last, lay_last, n_ok;
  logic              rd_en, wr_en, lay_en, err, done, start_ok;

  // One extra bit so that BUTTS-1 of the largest transform still fits.
  assign butts_m1 = ((ButtWL+1)'(1) << (cfg - LayWL'(1))) - (ButtWL+1)'(1);
  assign rd_last  = ({1'b0, rd_cnt} == butts_m1);
  assign wr_last  = ({1'b0, wr_cnt} == butts_m1);
  assign lay_last = (lay_idx == cfg - LayWL'(1));
  assign n_ok     = (bus.N_LOG2 != '0) && (bus.N_LOG2 <= LayWL'(LAYERS_MAX));
  assign vpipe_shift = {vpipe, rd_en};

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    lay_en    = 1'b0;
    err       = 1'b0;
    done      = 1'b0;
    start_ok  = 1'b0;
    wr_en     = vpipe[BUT_LAT-1] & bus.EN;
    case (state)
      S_IDLE: begin
        if (bus.EN && bus.START && !bus.ABORT) begin
          if (n_ok) begin
            start_ok  = 1'b1;
            state_nxt = S_RUN;
          end else begin
            err = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (bus.EN) begin
          rd_en = 1'b1;
          if (rd_last) state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // The next layer may only start once its last write-back has retired,
        // since the transform is computed in place.
        if (wr_en && wr_last) begin
          if (lay_last) begin
            state_nxt = S_DONE;
          end else begin
            lay_en    = 1'b1;
            state_nxt = S_RUN;
          end
        end
      end
      S_DONE: begin
        if (bus.EN) begin
          done      = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (bus.EN && bus.ABORT) begin
      state_nxt = S_IDLE;
      rd_en     = 1'b0;
      lay_en    = 1'b0;
      done      = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_IDLE;
      cfg     <= '0;
      lay_idx <= '0;
      rd_cnt  <= '0;
      wr_cnt  <= '0;
      vpipe   <= '0;
    end else if (bus.EN) begin
      state <= state_nxt;
      if (bus.ABORT) begin
        lay_idx <= '0;
        rd_cnt  <= '0;
        wr_cnt  <= '0;
        vpipe   <= '0;
      end else begin
        vpipe <= vpipe_shift[BUT_LAT-1:0];
        if (start_ok) begin
          cfg     <= bus.N_LOG2;
          lay_idx <= '0;
          rd_cnt  <= '0;
          wr_cnt  <= '0;
        end
        if (rd_en) rd_cnt <= rd_last ? '0 : rd_cnt + ButtWL'(1);
        if (wr_en) wr_cnt <= wr_last ? '0 : wr_cnt + ButtWL'(1);
        if (lay_en) lay_idx <= lay_idx + LayWL'(1);
        if (state == S_DONE) lay_idx <= '0;
      end
    end
  end

  assign bus.BUSY       = (state == S_RUN) || (state == S_DRAIN);
  assign bus.DONE       = done;
  assign bus.ERR        = err;
  assign bus.RD_EN      = rd_en;
  assign bus.RD_BUT_IDX = rd_cnt;
  assign bus.WR_EN      = wr_en;
  assign bus.WR_BUT_IDX = wr_cnt;
  assign bus.LAY_IDX    = lay_idx;
  assign bus.LAY_EN     = lay_en;
  assign bus.LAST_LAY   = bus.BUSY && lay_last;
  assign bus.ADDR_RST   = (state == S_IDLE) || (state == S_DONE);

endmodule

// File: doc/control_unit_fft_iter_pipe.md
Name: control_unit_fft_iter_pipe

Overview:
Parametrised sequencer for the in-place iterative radix-2 FFT core. It succeeds the two-cycle-per-butterfly controller with a pipelined schedule: one butterfly read is issued per cycle, and each write-back follows a fixed butterfly latency. FFT size is selected at run time (N = 2^N_LOG2). The block drives the address generator, RAM enables and twiddle/layer logic of the iterative FFT datapath.

Parameters:
LAYERS_MAX, 10, maximum number of layers (max FFT size 2^LAYERS_MAX)
LayWL, 4, layer counter / N_LOG2 width; must satisfy 2^LayWL > LAYERS_MAX
ButtWL, 9, butterfly counter width; must satisfy ButtWL >= LAYERS_MAX-1
BUT_LAT, 3, cycles from read issue to write-back, >= 1

Ports:
CLK  in  1  clock, all logic on posedge
RST  in  1  synchronous, active-high reset
EN  in  1  global cycle enable; when low, all state, counters and the pipeline freeze and RD_EN/WR_EN are forced 0
START  in  1  start request, sampled in IDLE
ABORT  in  1  cancel the current transform
N_LOG2  in  LayWL  transform size select, sampled with START
BUSY  out  1  high in RUN and DRAIN
DONE  out  1  one-cycle pulse on completion
ERR  out  1  one-cycle pulse when START is rejected
RD_EN  out  1  butterfly read strobe (RAM read enable, address generator advance)
RD_BUT_IDX  out  ButtWL  butterfly index of the current read
WR_EN  out  1  write-back strobe
WR_BUT_IDX  out  ButtWL  butterfly index of the current write
LAY_IDX  out  LayWL  current layer, 0-based
LAY_EN  out  1  one-cycle pulse on layer advance
LAST_LAY  out  1  high while LAY_IDX == cfg-1 in RUN/DRAIN
ADDR_RST  out  1  high in IDLE and DONE

Behaviour:
- Reset: state IDLE; cfg, rd_cnt, wr_cnt, LAY_IDX and the valid pipe are 0; every output is 0 except ADDR_RST=1.
- Internal quantities: cfg = latched N_LOG2; BUTTS = 2^(cfg-1).
- IDLE: on START & EN & !ABORT:
  - if 1 <= N_LOG2 <= LAYERS_MAX: latch cfg, clear counters, go to RUN.
  - otherwise stay in IDLE and pulse ERR.
- RUN: each EN cycle, RD_EN=1 and RD_BUT_IDX=rd_cnt, then rd_cnt++. When rd_cnt == BUTTS-1, go to DRAIN (rd_cnt returns to 0).
- Valid pipe: BUT_LAT-stage shift register fed by RD_EN, shifting only on EN.
  - WR_EN = last stage, so a write occurs exactly BUT_LAT enabled cycles after its read.
  - WR_BUT_IDX = wr_cnt; wr_cnt++ on each WR_EN and wraps to 0 after BUTTS-1.
  - Writes may overlap RUN.
- DRAIN: no reads. On the cycle where WR_EN & wr_cnt == BUTTS-1:
  - if LAY_IDX == cfg-1: go to DONE.
  - else: LAY_EN=1 that cycle, LAY_IDX++ at the edge, go to RUN.
  - No read of layer k+1 is issued before the last write of layer k (in-place hazard).
- Per-layer cycle count = BUTTS + BUT_LAT.
- DONE: DONE=1 for one cycle, BUSY=0, then IDLE. A START in DONE is ignored.
- ABORT (any state, EN high): next state IDLE, valid pipe cleared, counters cleared, no DONE. ABORT has priority over START on the same cycle.
- RST mid-transform: identical to ABORT, and cfg is also cleared.
- EN low during RUN/DRAIN: full freeze; resumes without loss or duplication of reads or writes.
- N_LOG2=1: one layer, one butterfly; LAST_LAY is high for the whole run.
- Counters are unsigned and wrap only at the defined boundaries; no counter exceeds BUTTS-1 or cfg-1.

Test Plan:
- BUT_LAT=3, N_LOG2=3, EN=1, START at cycle 0 -> reads in cycles 1-4, 8-11, 15-18; writes in cycles 4-7, 11-14, 18-21; LAY_EN pulses at cycles 7 and 14; LAST_LAY high cycles 15-21; DONE at cycle 22; BUSY high cycles 1-21.
- N_LOG2=1, BUT_LAT=1 -> RD_EN at cycle 1, WR_EN at cycle 2, DONE at cycle 3, no LAY_EN pulse.
- N_LOG2=0 and then N_LOG2=11 with START -> ERR pulse each time, BUSY stays 0, state stays IDLE.
- Scenario 1 with EN low for cycles 9-10 -> reads shift to cycles 8, 11, 12, 13; DONE moves to cycle 24; read/write counts unchanged (12 of each).
- ABORT at cycle 9 of scenario 1 -> BUSY=0 from cycle 10, no further WR_EN, no DONE. A new START at cycle 12 restarts from layer 0 with butterfly index 0.
- START and ABORT together in IDLE -> no start. RST asserted during DRAIN -> all outputs take their reset values on the next cycle.
